// File: rtl/button_debouncer.sv
// ---------------------------------------------------------------------------
// button_debouncer
//
// Turns a raw, asynchronous push-button level into clean signals in the
// clock domain. The input passes through a two-flop synchroniser. A
// four-state FSM then accepts a new level only after the synchronised input
// has held that level for STABLE_COUNT consecutive cycles.
//
// Parameters:
//   STABLE_COUNT  cycles a new level must persist before it is accepted
//                 (legal range 1 .. 2^32-1)
//
// Ports:
//   clock          board clock; every flop uses its rising edge
//   reset          synchronous, active-high; clears all state
//   button_in      raw button level; may bounce and is asynchronous
//   button_level   debounced level
//   press_pulse    one-cycle pulse for each accepted 0->1 transition
//   release_pulse  one-cycle pulse for each accepted 1->0 transition
//   debug_state    current FSM state, for observation only
//
// There is no valid/ready handshake. button_in is a free-running level.
// Both pulses are registered, single-cycle, and mutually exclusive.
// ---------------------------------------------------------------------------
module button_debouncer #(
  parameter int unsigned STABLE_COUNT = 500000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       button_in,
  output logic       button_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic [1:0] debug_state
);

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    HOLD_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  // Terminal count. A WAIT state that reaches this value has seen
  // STABLE_COUNT consecutive cycles of the new level.
  localparam logic [31:0] LAST_COUNT = 32'(STABLE_COUNT - 1);

  state_t      state;
  state_t      state_next;
  logic        sync1;
  logic        sync2;
  logic [31:0] count;
  logic [31:0] count_next;
  logic        level_next;
  logic        press_next;
  logic        release_next;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1         <= 1'b0;
      sync2         <= 1'b0;
      state         <= IDLE_LOW;
      count         <= 32'd0;
      button_level  <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      sync1         <= button_in;
      sync2         <= sync1;
      state         <= state_next;
      count         <= count_next;
      button_level  <= level_next;
      press_pulse   <= press_next;
      release_pulse <= release_next;
    end
  end

  // The FSM looks only at sync2. It never looks at button_in or sync1.
  always_comb begin
    state_next   = state;
    count_next   = count;
    level_next   = button_level;
    press_next   = 1'b0;
    release_next = 1'b0;
    case (state)
      IDLE_LOW: begin
        if (sync2) begin
          state_next = WAIT_HIGH;
          count_next = 32'd0;
        end
      end
      WAIT_HIGH: begin
        if (!sync2) begin
          // The input went low before qualifying: treat it as a bounce.
          state_next = IDLE_LOW;
          count_next = 32'd0;
        end else if (count == LAST_COUNT) begin
          state_next = HOLD_HIGH;
          level_next = 1'b1;
          press_next = 1'b1;
          count_next = 32'd0;
        end else begin
          count_next = count + 32'd1;
        end
      end
      HOLD_HIGH: begin
        if (!sync2) begin
          state_next = WAIT_LOW;
          count_next = 32'd0;
        end
      end
      WAIT_LOW: begin
        if (sync2) begin
          state_next = HOLD_HIGH;
          count_next = 32'd0;
        end else if (count == LAST_COUNT) begin
          state_next   = IDLE_LOW;
          level_next   = 1'b0;
          release_next = 1'b1;
          count_next   = 32'd0;
        end else begin
          count_next = count + 32'd1;
        end
      end
      default: begin
        state_next = IDLE_LOW;
        count_next = 32'd0;
      end
    endcase
  end

  assign debug_state = state;

endmodule
